serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter n, default 16: operand, difference and shift-register width (n >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled on rising clk.
REQ-005 SHALL have port a  input  n  minuend; sampled only on the accepting edge.
REQ-006 SHALL have port b  input  n  subtrahend; sampled only on the accepting edge.
REQ-007 SHALL have port bin  input  1  borrow-in; sampled only on the accepting edge.
REQ-008 SHALL have port diff  output  n  registered result a-b-bin, modulo 2^n.
REQ-009 SHALL have port bout  output  1  registered borrow-out; 1 iff a < b+bin (unsigned).
REQ-010 SHALL have port busy  output  1  high while in BUSY.
REQ-011 SHALL have port done  output  1  one-cycle pulse when diff/bout become valid.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL accept a request at a rising edge when start=1 and state is IDLE or DONE; this edge is the accepting edge.
REQ-014 SHALL on the accepting edge load a and b into shift registers, load bin into the borrow flop, clear the bit counter and enter BUSY.
REQ-015 SHALL in BUSY process one bit per edge, LSB first: diff bit = a^b^borrow; new borrow = (~a&b)|(~(a^b)&borrow).
REQ-016 SHALL shift each difference bit into the diff register from the MSB end, so diff is correctly aligned after n shifts.
REQ-017 SHALL count processed bits with a counter of width clog2(n); on the n-th BUSY edge enter DONE.
REQ-018 SHALL update bout only on the n-th BUSY edge, with the final borrow.
REQ-019 SHALL have a latency of exactly n edges: done rises at the n-th edge after the accepting edge and stays high for one cycle.
REQ-020 SHALL leave DONE for IDLE on the next edge when start=0.
REQ-021 SHALL, when start=1 in DONE, accept a new request on that edge (back-to-back); done then falls and busy rises.
REQ-022 SHALL ignore start while BUSY; a, b and bin changes during BUSY SHALL NOT affect the result.
REQ-023 SHALL hold diff and bout stable from done until the next accepting edge; diff is not valid while busy=1.
REQ-024 SHALL keep busy=1 only in BUSY and done=1 only in DONE; the two are never high together.

Reset
REQ-025 SHALL, on rst=1, immediately and asynchronously clear state to IDLE, diff to 0, bout to 0, busy to 0, done to 0, and the counter, borrow flop and shift registers to 0.
REQ-026 SHALL, when rst asserts mid-operation, abort the operation and produce no done pulse; the next operation starts with a fresh start after rst deasserts.
REQ-027 SHALL not accept start on an edge where rst is asserted.

Structure
REQ-028 SHALL take state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default width constant from a shared package or include, sub_pkg.
REQ-029 SHALL instantiate the per-bit logic as one sub-module, S_fullsubtractor (inputs a, b, bin; outputs d, bout), the subtract counterpart of S_fulladder.
REQ-030 SHALL keep the datapath to one S_fullsubtractor instance plus the shift registers, borrow flop and counter; no n-wide combinational subtractor.

Verification
REQ-031 SHALL test basic subtraction (n=16): a=0x1234, b=0x0034, bin=0, start pulse -> done at edge 16 after acceptance, diff=0x1200, bout=0.
REQ-032 SHALL test underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
REQ-033 SHALL test back-to-back: start held high across DONE with a=0x8000, b=0x0001 -> second done exactly 16 edges after the first, diff=0x7FFF, bout=0, busy never low in between.
REQ-034 SHALL test input stability: change a, b and bin and pulse start during BUSY -> result equals the originally latched operands, and only one done pulse occurs.
REQ-035 SHALL test reset mid-operation: assert rst at BUSY bit 7 -> outputs immediately 0 and state IDLE; no done pulse; a following operation 0xFFFF-0xFFFF gives diff=0, bout=0.
REQ-036 SHALL test a random sweep against a reference model of {bout,diff} = {1'b0,a} - b - bin, including the n=4 parameter variant.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_pkg;

  // Default operand / difference / shift-register width.
  localparam int DEFAULT_N = 16;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/S_fullsubtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module S_fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of all three inputs.
  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they match and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial n-bit subtractor: diff/bout = a - b - bin using one full subtractor.
// Latency: done pulses exactly n edges after the accepting edge.
// Backpressure: start is ignored while busy; a new request is taken in IDLE or DONE.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic [n-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  // Bit counter is just wide enough to index n bits; LAST marks the n-th BUSY edge.
  localparam int            CW   = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t        state;
  logic [n-1:0]  a_sr;
  logic [n-1:0]  b_sr;
  logic          borrow;
  logic [CW-1:0] cnt;
  logic          d_bit;
  logic          b_bit;

  // The only arithmetic in the datapath: the LSBs of the shift registers
  // and the running borrow.
  S_fullsubtractor u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (d_bit),
    .bout(b_bit)
  );

  // Controller and datapath: load on accept, shift one bit per BUSY edge, publish on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Operands are captured only here; later input changes cannot leak in.
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= BUSY;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        BUSY: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= b_bit;
          // Bits enter at the MSB so the LSB-first stream lands aligned after n shifts.
          diff   <= {d_bit, diff[n-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= b_bit;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
